// File: rtl/twiddle_gen.sv
// twiddle_gen: streaming FFT twiddle generator rebuilding W_N^k from a quarter-wave cosine table.
// Optional macro TWIDDLE_IFFT_EN adds the inverse port, which conjugates the output (IFFT twiddles).
module twiddle_gen #(
   parameter int N_MAX = 4096,
   parameter int HW    = 16,
   localparam int LOGN = $clog2(N_MAX),
   localparam int LW   = $clog2(LOGN + 1),
   localparam int SW   = $clog2(LOGN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [LW-1:0]   len_log2,
   input  logic [SW-1:0]   stride_log2,
`ifdef TWIDDLE_IFFT_EN
   input  logic            inverse,
`endif
   output logic            busy,
   output logic            tw_valid,
   input  logic            tw_ready,
   output logic [2*HW-1:0] tw_data,
   output logic [LOGN-1:0] tw_idx,
   output logic            tw_last,
   output logic            done
);
   localparam int Q4   = N_MAX / 4;
   localparam int FRAC = 30;
   localparam logic [LOGN-1:0] K_ONE = {{(LOGN-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   // Table entry C[m] = round(cos(2*pi*m/N_MAX) * (2^(HW-1)-1)), evaluated at elaboration in Q30 fixed point.
   function automatic logic [HW-1:0] cos_entry(input int m);
      longint x, x2, term, acc;
      x    = (64'sd6746518852 * longint'(m)) / longint'(N_MAX);
      x2   = (x * x) >>> FRAC;
      term = 64'sd1073741824;
      acc  = term;
      for (int i = 1; i <= 12; i++) begin
         term = -(((term * x2) >>> FRAC) / longint'((2 * i - 1) * (2 * i)));
         acc  = acc + term;
      end
      acc = (acc * longint'((1 << (HW - 1)) - 1) + 64'sd536870912) >>> FRAC;
      return (acc < 64'sd0) ? '0 : acc[HW-1:0];
   endfunction

   logic [HW-1:0] rom_s [0:Q4];
   for (genvar m = 0; m <= Q4; m++) begin : g_rom
      localparam logic [HW-1:0] C_M = cos_entry(m);
      assign rom_s[m] = C_M;
   end

   state_t          state_r;
   logic [LOGN-1:0] j_r;
   logic [LW-1:0]   len_r;
   logic [SW-1:0]   stride_r;
   logic            s1_valid_r, s1_last_r, s2_valid_r, s2_last_r;
   logic [LOGN-1:0] s1_k_r, s2_k_r;
   logic [HW-1:0]   s2_c_r, s2_cq_r;
   logic            stall_s, is_last_s, inv_s;
   logic [LOGN:0]   span_s;
   logic [LOGN-1:0] last_j_s, k_s;
   logic [LOGN-2:0] r_s, rq_s;
   logic [HW-1:0]   re_s, im_s, im_out_s;

   assign stall_s = tw_valid & ~tw_ready;
   assign r_s     = {1'b0, s1_k_r[LOGN-3:0]};
   assign rq_s    = (LOGN-1)'(Q4) - r_s;

   // Sequence bookkeeping: final j of the run and the strided index it maps to.
   always_comb begin
      span_s    = {{LOGN{1'b0}}, 1'b1} << len_r;
      last_j_s  = LOGN'(span_s - {{LOGN{1'b0}}, 1'b1});
      k_s       = j_r << stride_r;
      is_last_s = (j_r == last_j_s);
   end

   // Control FSM and address stage; everything freezes while the consumer stalls a valid beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         j_r        <= '0;
         len_r      <= '0;
         stride_r   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         s1_valid_r <= 1'b0;
         s1_last_r  <= 1'b0;
         s1_k_r     <= '0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  len_r    <= (len_log2 > LW'(LOGN)) ? LW'(LOGN) : len_log2;
                  stride_r <= stride_log2;
                  j_r      <= '0;
                  busy     <= 1'b1;
                  state_r  <= RUN;
               end
            end
            RUN: begin
               if (!stall_s) begin
                  s1_valid_r <= 1'b1;
                  s1_k_r     <= k_s;
                  s1_last_r  <= is_last_s;
                  j_r        <= j_r + K_ONE;
                  if (is_last_s) begin
                     state_r <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!stall_s) begin
                  s1_valid_r <= 1'b0;
                  s1_last_r  <= 1'b0;
               end
               if (tw_valid && tw_ready && tw_last) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef TWIDDLE_IFFT_EN
   logic inv_r;
   // Conjugate select, latched with the request and held for the whole sequence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inv_r <= 1'b0;
      end else if (state_r == IDLE && start) begin
         inv_r <= inverse;
      end
   end
   assign inv_s = inv_r;
`else
   assign inv_s = 1'b0;
`endif

   // Table stage: both symmetric entries C[r] and C[Q4-r] are read every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_r <= 1'b0;
         s2_last_r  <= 1'b0;
         s2_k_r     <= '0;
         s2_c_r     <= '0;
         s2_cq_r    <= '0;
      end else if (!stall_s) begin
         s2_valid_r <= s1_valid_r;
         s2_last_r  <= s1_last_r;
         s2_k_r     <= s1_k_r;
         s2_c_r     <= rom_s[r_s];
         s2_cq_r    <= rom_s[rq_s];
      end
   end

   // Quadrant reconstruction of cos/-sin from the two table reads.
   always_comb begin
      re_s = '0;
      im_s = '0;
      case (s2_k_r[LOGN-1:LOGN-2])
         2'd0: begin re_s = s2_c_r;   im_s = -s2_cq_r; end
         2'd1: begin re_s = -s2_cq_r; im_s = -s2_c_r;  end
         2'd2: begin re_s = -s2_c_r;  im_s = s2_cq_r;  end
         2'd3: begin re_s = s2_cq_r;  im_s = s2_c_r;   end
         default: begin re_s = '0;    im_s = '0;       end
      endcase
      if (inv_s) begin
         im_out_s = -im_s;
      end else begin
         im_out_s = im_s;
      end
   end

   // Output register: holds the presented beat until it is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tw_valid <= 1'b0;
         tw_last  <= 1'b0;
         tw_data  <= '0;
         tw_idx   <= '0;
      end else if (!stall_s) begin
         tw_valid <= s2_valid_r;
         tw_last  <= s2_last_r;
         tw_data  <= {re_s, im_out_s};
         tw_idx   <= s2_k_r;
      end
   end
endmodule
